hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

- Detects read-after-write hazards in the ID stage and drives `hazard_detected` into the controller.
- Keeps a two-entry shadow pipeline with the destination register and the load flag of each instruction in EXE and MEM. The controller's own `WB_EN` and `MEM_R_EN` outputs fill this shadow pipeline.
- Sits between the ID-stage decode (controller, register-field extraction) and the ID/EX pipeline register.
- Also counts stall cycles for performance monitoring.

## Interface

Parameters:
- `CNT_WIDTH`, default 16: width of the saturating stall-cycle counter.
- `REG_ADDR_W`, default 5: register-address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction (0 = bubble).
- `src1` in `REG_ADDR_W`: first source register of the ID instruction; always read.
- `src2` in `REG_ADDR_W`: second source register.
- `two_src` in 1: the ID instruction reads `src2`. Decode drives this as `~Is_Imm | ST_or_BNE`.
- `id_dest` in `REG_ADDR_W`: destination register of the ID instruction.
- `id_wb_en` in 1: controller `WB_EN` for the ID instruction, taken before the hazard gating.
- `id_mem_r_en` in 1: controller `MEM_R_EN` for the ID instruction.
- `fwd_en` in 1: forwarding unit active.
- `flush` in 1: taken branch resolved in EXE; the ID instruction is killed this cycle.
- `hazard_detected` out 1: stall ID/IF and inject a bubble into EXE.
- `stall_count` out `CNT_WIDTH`: number of cycles with `hazard_detected` = 1, saturating.

## Operation

Shadow entries:
- EX entry: `ex_wb`, `ex_dest`, `ex_mem_r`.
- MEM entry: `mem_wb`, `mem_dest`.
- WB stage is not tracked. The register file writes before the read in the same cycle.

Issue condition: `issue = id_valid & ~hazard_detected & ~flush`.

Update on each rising edge:
- MEM entry <= EX entry (`mem_wb` <= `ex_wb`, `mem_dest` <= `ex_dest`).
- If `issue & id_wb_en & (id_dest != 0)`: EX entry <= {1, `id_dest`, `id_mem_r_en`}.
- Otherwise: EX entry <= bubble {0, 0, 0}.

Source match:
- `srcK` matches entry X when `srcK != 0`, `X.wb` = 1 and `srcK == X.dest`.
- `src2` is only considered when `two_src` = 1.
- Register 0 never creates a hazard.

`hazard_detected`, combinational from the inputs and registered state:
- 0 if `flush` = 1 or `id_valid` = 0.
- If `fwd_en` = 0: 1 when any considered source matches the EX entry or the MEM entry.
- If `fwd_en` = 1: 1 only when a considered source matches the EX entry and `ex_mem_r` = 1 (load-use). MEM matches are resolved by forwarding.

Stall counter:
- Increments by 1 on each edge where `hazard_detected` = 1.
- Holds at 2^`CNT_WIDTH` − 1; it does not wrap.
- Cleared only by reset.

Resulting stall lengths:
- `fwd_en` = 0, dependency on the immediately preceding instruction: 2 stall cycles.
- `fwd_en` = 0, dependency on the instruction two ahead: 1 stall cycle.
- `fwd_en` = 1, load-use dependency: exactly 1 stall cycle.
- `fwd_en` = 1, any other dependency: 0 stall cycles.

## Timing

Reset (`rst` = 1):
- Both entries are cleared to invalid, all fields 0.
- `stall_count` = 0.
- `hazard_detected` = 0, because no entry is valid.
- Reset is asynchronous and applies immediately, including in the middle of a stall. The first cycle after release never stalls.

Latency:
- `hazard_detected` is valid in the same cycle as the ID inputs; there is no register in that path.
- An issued instruction becomes visible in the EX entry one edge later and in the MEM entry two edges later.

Boundary behaviour:
- `flush` and a would-be hazard in the same cycle: `hazard_detected` = 0, a bubble enters EX, and `stall_count` does not increment.
- `fwd_en` changing mid-stall: the new value takes effect in the same cycle. The shadow entries are unaffected.
- A stalled instruction's own `id_wb_en` is never recorded. The bubble keeps it out of the EX entry until it issues.
- `id_dest` = 0 with `id_wb_en` = 1 is recorded as a bubble.

## Test plan

1. **Reset mid-stall.**
   - Stimulus: assert `rst` while `hazard_detected` = 1, then release. Present `src1` = 3 with `id_valid` = 1.
   - Required: `hazard_detected` = 0 immediately and after release; `stall_count` = 0.
2. **No forwarding, back-to-back dependency.**
   - Stimulus: `fwd_en` = 0. Issue `ADD r5`, then `SUB` with `src1` = 5.
   - Required: `hazard_detected` = 1 for exactly 2 cycles, then 0; `stall_count` = 2.
3. **Load-use with forwarding.**
   - Stimulus: `fwd_en` = 1. Issue a load to r7 (`id_mem_r_en` = 1), then an ALU op with `two_src` = 1 and `src2` = 7.
   - Required: exactly 1 stall cycle.
   - Repeat with a non-load producing r7: 0 stall cycles.
4. **Register 0 and immediate ops.**
   - Stimulus: write r0, then read r0 → no stall.
   - Stimulus: write r4, then an immediate op with `two_src` = 0 and `src2` = 4 → no stall.
5. **Flush priority.**
   - Stimulus: a hazard is pending and `flush` = 1 in the same cycle.
   - Required: `hazard_detected` = 0, `stall_count` unchanged, and the EX entry holds a bubble on the next cycle.
6. **Counter saturation.**
   - Stimulus: `CNT_WIDTH` = 2; force 5 consecutive stall cycles.
   - Required: `stall_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
//   ID-stage read-after-write hazard detector. It keeps a shadow copy of the
//   destination register and the load flag for the instructions in EXE and
//   MEM. When an ID source would read a value that is not yet available, it
//   raises hazard_detected, and it counts stall cycles in a saturating counter.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   id_valid          : ID holds a real instruction
//   src1/src2/two_src : ID source registers; src2 is used only when two_src=1
//   id_dest           : ID destination register
//   id_wb_en          : ID writes back (ungated controller WB_EN)
//   id_mem_r_en       : ID is a load (controller MEM_R_EN)
//   fwd_en            : forwarding unit active
//   flush             : taken branch in EXE, so the ID instruction is killed
//   hazard_detected   : stall IF/ID and inject a bubble into EXE (combinational)
//   stall_count       : saturating count of cycles with hazard_detected=1
module hazard_detection_unit #(
  parameter int CNT_WIDTH  = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  fwd_en,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef struct packed {
    logic                  wb;
    logic [REG_ADDR_W-1:0] dest;
    logic                  mem_r;
  } ex_ent_t;

  typedef struct packed {
    logic                  wb;
    logic [REG_ADDR_W-1:0] dest;
  } mem_ent_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  ex_ent_t              ex_q, ex_d;
  mem_ent_t             mem_q, mem_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic s1_nz, s2_used;
  logic hit_ex, hit_mem;
  logic haz, issue;

  // Register 0 is hard-wired, so it never matches. src2 counts only for
  // instructions that read it.
  assign s1_nz   = |src1;
  assign s2_used = two_src & (|src2);

  assign hit_ex  = ex_q.wb  & ((s1_nz & (src1 == ex_q.dest))  | (s2_used & (src2 == ex_q.dest)));
  assign hit_mem = mem_q.wb & ((s1_nz & (src1 == mem_q.dest)) | (s2_used & (src2 == mem_q.dest)));

  // With forwarding enabled, the only hazard left is a load in EXE, because
  // its data arrives too late to forward. A killed or empty ID slot never stalls.
  assign haz   = id_valid & ~flush & (fwd_en ? (hit_ex & ex_q.mem_r) : (hit_ex | hit_mem));
  assign issue = id_valid & ~haz & ~flush;

  always_comb begin
    mem_d = '{wb: ex_q.wb, dest: ex_q.dest};
    ex_d  = '0;
    // A destination of 0 is stored as a bubble so that it can never match.
    if (issue && id_wb_en && (id_dest != '0))
      ex_d = '{wb: 1'b1, dest: id_dest, mem_r: id_mem_r_en};
  end

  always_comb begin
    cnt_d = cnt_q;
    if (haz && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign hazard_detected = haz;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, two_src, id_wb_en, id_mem_r_en, fwd_en, flush;
  logic [4:0] src1, src2, id_dest;
  logic       haz, haz2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_detection_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .fwd_en(fwd_en), .flush(flush),
    .hazard_detected(haz), .stall_count(cnt)
  );

  hazard_detection_unit #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .fwd_en(fwd_en), .flush(flush),
    .hazard_detected(haz2), .stall_count(cnt2)
  );

  typedef struct {
    logic       valid;
    logic [4:0] s1, s2;
    logic       two;
    logic [4:0] dest;
    logic       wb, mr, fwd, fl;
    logic       exp_haz;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, int s1, int s2, logic two, int d, logic wb,
                              logic mr, logic fwd, logic fl, logic eh, int ec);
    vec_t r;
    r.valid = v; r.s1 = 5'(s1); r.s2 = 5'(s2); r.two = two; r.dest = 5'(d);
    r.wb = wb; r.mr = mr; r.fwd = fwd; r.fl = fl; r.exp_haz = eh; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    id_valid = v.valid; src1 = v.s1; src2 = v.s2; two_src = v.two;
    id_dest = v.dest; id_wb_en = v.wb; id_mem_r_en = v.mr;
    fwd_en = v.fwd; flush = v.fl;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single-source op with no forwarding, driven at the negedge.
  task automatic step(input logic v, input int s1, input int d, input logic wb);
    @(negedge clk);
    apply(mk(v, s1, 0, 0, d, wb, 0, 0, 0, 0, 0));
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("reset_haz", int'(haz), 0);
    chk("reset_cnt", int'(cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fields: valid s1 s2 two dest wb mr fwd flush | exp_haz exp_cnt (count before this edge)
    // No forwarding: back-to-back dependency, then a dependency two ahead.
    tbl.push_back(mk(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));  // ADD r5
    tbl.push_back(mk(1, 5, 6, 1, 8, 1, 0, 0, 0, 1, 0));  // SUB r5 hits EX
    tbl.push_back(mk(1, 5, 6, 1, 8, 1, 0, 0, 0, 1, 1));  // hits MEM
    tbl.push_back(mk(1, 5, 6, 1, 8, 1, 0, 0, 0, 0, 2));  // issues
    tbl.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 2));  // bubble
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 2));  // r8 in MEM
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // Forwarding: load-use stalls once, a non-load producer never stalls.
    tbl.push_back(mk(1, 1, 0, 0, 7, 1, 1, 1, 0, 0, 3));  // LD r7
    tbl.push_back(mk(1, 2, 7, 1, 9, 1, 0, 1, 0, 1, 3));  // use via src2
    tbl.push_back(mk(1, 2, 7, 1, 9, 1, 0, 1, 0, 0, 4));  // forwarded from MEM
    tbl.push_back(mk(1, 0, 0, 0, 7, 1, 0, 1, 0, 0, 4));  // ADD r7
    tbl.push_back(mk(1, 9, 7, 1, 10, 0, 0, 1, 0, 0, 4)); // r7 in EX, r9 in MEM
    // Switching fwd_en off takes effect at once: the MEM match on r7 now stalls.
    tbl.push_back(mk(1, 9, 7, 1, 10, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(1, 9, 7, 1, 10, 0, 0, 0, 0, 0, 5));
    // Register 0 and immediate ops.
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 5));  // write r0
    tbl.push_back(mk(1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 5));  // read r0, write r4
    tbl.push_back(mk(1, 1, 4, 0, 6, 0, 0, 0, 0, 0, 5));  // imm op, src2=4 ignored
    tbl.push_back(mk(1, 1, 4, 1, 6, 0, 0, 0, 0, 1, 5));  // same with two_src: stall
    tbl.push_back(mk(1, 1, 4, 1, 6, 0, 0, 0, 0, 0, 6));
    // Flush wins over a pending hazard, and the killed op leaves a bubble.
    tbl.push_back(mk(1, 1, 0, 0, 11, 1, 0, 0, 0, 0, 6)); // ADD r11
    tbl.push_back(mk(1, 11, 0, 0, 12, 1, 0, 0, 1, 0, 6));// would stall, flushed
    tbl.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 6)); // r12 never recorded

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("vec%0d_haz", i), int'(haz), int'(tbl[i].exp_haz));
      chk($sformatf("vec%0d_cnt", i), int'(cnt), tbl[i].exp_cnt);
    end

    // Reset in the middle of a stall.
    do_reset();
    step(1, 1, 3, 1);                // ADD r3
    step(1, 3, 0, 0);
    chk("rst_pre_haz", int'(haz), 1);
    step(1, 3, 0, 0);                // second stall cycle
    chk("rst_pre_cnt", int'(cnt), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_haz", int'(haz), 0);
    chk("rst_mid_cnt", int'(cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_post_haz", int'(haz), 0);
    chk("rst_post_cnt", int'(cnt), 0);

    // Saturation of the 2-bit counter across chained dependencies.
    do_reset();
    step(1, 1, 3, 1);                // A: r3
    step(1, 3, 4, 1);                // B reads r3
    chk("sat_b1_haz", int'(haz2), 1);
    step(1, 3, 4, 1);
    chk("sat_cnt1", int'(cnt2), 1);
    step(1, 3, 4, 1);                // B issues
    chk("sat_cnt2", int'(cnt2), 2);
    chk("sat_b_issue_haz", int'(haz2), 0);
    step(1, 4, 5, 1);                // C reads r4
    step(1, 4, 5, 1);
    chk("sat_cnt3", int'(cnt2), 3);
    step(1, 4, 5, 1);                // C issues
    chk("sat_cnt4", int'(cnt2), 3);
    step(1, 5, 0, 0);                // D reads r5
    chk("sat_d_haz", int'(haz2), 1);
    step(1, 5, 0, 0);
    chk("sat_cnt5", int'(cnt2), 3);
    chk("sat_wide_cnt", int'(cnt), 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
